// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / multiply-divide sequencer.
// Holds the R-type funct codes, ALUOp classes, ALUCtrl codes 0..14 and the FSM
// state encoding. Define ALU_CTRL_SEQ_DIV_EN to include the DIV state.
package alu_ctrl_pkg;

    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned CODE_W  = 4;

    // R-type funct field values
    localparam logic [FUNCT_W-1:0] FUNCT_SLL   = 6'd0;
    localparam logic [FUNCT_W-1:0] FUNCT_SRLV  = 6'd6;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'd24;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'd25;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'd26;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'd27;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'd32;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'd34;
    localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'd36;
    localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'd37;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'd42;

    // Main-control ALU operation classes
    localparam logic [CODE_W-1:0] ALUOP_RTYPE  = 4'b0001;
    localparam logic [CODE_W-1:0] ALUOP_ADDI   = 4'b0010;
    localparam logic [CODE_W-1:0] ALUOP_SLTI   = 4'b0011;
    localparam logic [CODE_W-1:0] ALUOP_ANDI   = 4'b0100;
    localparam logic [CODE_W-1:0] ALUOP_ORI    = 4'b0101;
    localparam logic [CODE_W-1:0] ALUOP_XORI   = 4'b0110;
    localparam logic [CODE_W-1:0] ALUOP_LUI    = 4'b0111;
    localparam logic [CODE_W-1:0] ALUOP_LOAD   = 4'b1000;
    localparam logic [CODE_W-1:0] ALUOP_STORE  = 4'b1001;
    localparam logic [CODE_W-1:0] ALUOP_BRANCH = 4'b1010;
    localparam logic [CODE_W-1:0] ALUOP_SLTIU  = 4'b1011;

    // ALUCtrl codes seen by the ALU
    localparam logic [CODE_W-1:0] ALU_AND     = 4'd0;
    localparam logic [CODE_W-1:0] ALU_OR      = 4'd1;
    localparam logic [CODE_W-1:0] ALU_ADD     = 4'd2;
    localparam logic [CODE_W-1:0] ALU_SUB     = 4'd3;
    localparam logic [CODE_W-1:0] ALU_SLT     = 4'd4;
    localparam logic [CODE_W-1:0] ALU_SLL     = 4'd5;
    localparam logic [CODE_W-1:0] ALU_SRLV    = 4'd6;
    localparam logic [CODE_W-1:0] ALU_AND_IMM = 4'd7;
    localparam logic [CODE_W-1:0] ALU_OR_IMM  = 4'd8;
    localparam logic [CODE_W-1:0] ALU_XOR_IMM = 4'd9;
    localparam logic [CODE_W-1:0] ALU_LUI     = 4'd10;
    localparam logic [CODE_W-1:0] ALU_MULT    = 4'd11;
    localparam logic [CODE_W-1:0] ALU_NOP     = 4'd12;
    localparam logic [CODE_W-1:0] ALU_SLTU    = 4'd13;
    localparam logic [CODE_W-1:0] ALU_DIV     = 4'd14;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef ALU_CTRL_SEQ_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    function automatic logic is_mul_funct(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

    function automatic logic is_div_funct(input logic [FUNCT_W-1:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath, one result bit per step.
// Multiply: radix-2 shift-add on operand magnitudes. Divide (only with
// ALU_CTRL_SEQ_DIV_EN): restoring divide on magnitudes, with a divide-by-zero
// bypass. Signs are re-applied combinationally on the final step.
// Ports:
//   clk_i, rst_i        clock, synchronous active-low reset
//   load_i              latch operands and clear the bit counter
//   step_i              advance one bit
//   is_div_i            (divide build only) latched operation is a divide
//   is_signed_i         treat operands as two's complement
//   src1_i, src2_i      rs / rt operands
//   last_c              current step is the final one
//   res_hi_c, res_lo_c  signed-corrected result of the current step
module alu_muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
`ifdef ALU_CTRL_SEQ_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             last_c,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH + 1;

    // acc_q: multiply = {carry, partial product, remaining multiplier bits}
    //        divide   = {0, partial remainder, dividend/quotient shift}
    logic [ACC_W-1:0] acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;

    logic             sign1_c;
    logic             sign2_c;
    logic [WIDTH-1:0] mag1_c;
    logic [WIDTH-1:0] mag2_c;
    logic [WIDTH:0]   addend_c;
    logic [WIDTH:0]   sum_c;
    logic [ACC_W-1:0] mul_nxt_c;
    logic [ACC_W-1:0] acc_nxt_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [2*WIDTH-1:0] prod_s_c;

    // Operand magnitudes for the signed forms
    assign sign1_c = is_signed_i & src1_i[WIDTH-1];
    assign sign2_c = is_signed_i & src2_i[WIDTH-1];
    assign mag1_c  = sign1_c ? -src1_i : src1_i;
    assign mag2_c  = sign2_c ? -src2_i : src2_i;

    // Shift-add step: add multiplicand when the low multiplier bit is set, shift right
    assign addend_c  = acc_q[0] ? {1'b0, opnd_q} : '0;
    assign sum_c     = acc_q[ACC_W-1:WIDTH] + addend_c;
    assign mul_nxt_c = {1'b0, sum_c, acc_q[WIDTH-1:1]};

    assign prod_c   = acc_nxt_c[2*WIDTH-1:0];
    assign prod_s_c = neg_q ? -prod_c : prod_c;

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_CTRL_SEQ_DIV_EN
    logic             div_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic [WIDTH-1:0] dvd_q;

    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic             ge_c;
    logic [WIDTH-1:0] rem_nxt_c;
    logic [ACC_W-1:0] div_nxt_c;
    logic [WIDTH-1:0] quo_c;
    logic [WIDTH-1:0] rem_c;

    // Restoring step: shift in the next dividend bit, subtract if it fits
    assign shifted_c = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial_c   = shifted_c - {1'b0, opnd_q};
    assign ge_c      = ~trial_c[WIDTH];
    assign rem_nxt_c = ge_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
    assign div_nxt_c = {1'b0, rem_nxt_c, acc_q[WIDTH-2:0], ge_c};

    assign acc_nxt_c = div_q ? div_nxt_c : mul_nxt_c;
    assign quo_c     = acc_nxt_c[WIDTH-1:0];
    assign rem_c     = acc_nxt_c[2*WIDTH-1:WIDTH];

    // Quotient truncates toward zero; remainder follows the dividend's sign
    always_comb begin
        res_hi_c = prod_s_c[2*WIDTH-1:WIDTH];
        res_lo_c = prod_s_c[WIDTH-1:0];
        if (div_q) begin
            if (dz_q) begin
                res_hi_c = dvd_q;
                res_lo_c = '1;
            end else begin
                res_hi_c = neg_rem_q ? -rem_c : rem_c;
                res_lo_c = neg_q ? -quo_c : quo_c;
            end
        end
    end
`else
    assign acc_nxt_c = mul_nxt_c;
    assign res_hi_c  = prod_s_c[2*WIDTH-1:WIDTH];
    assign res_lo_c  = prod_s_c[WIDTH-1:0];
`endif

    // Operand latch on load, one bit per step afterwards
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
`ifdef ALU_CTRL_SEQ_DIV_EN
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            dvd_q     <= '0;
`endif
        end else if (load_i) begin
            cnt_q <= '0;
            neg_q <= sign1_c ^ sign2_c;
`ifdef ALU_CTRL_SEQ_DIV_EN
            div_q     <= is_div_i;
            neg_rem_q <= sign1_c;
            dz_q      <= (src2_i == '0);
            dvd_q     <= src1_i;
            opnd_q    <= is_div_i ? mag2_c : mag1_c;
            acc_q     <= {{(WIDTH + 1){1'b0}}, (is_div_i ? mag1_c : mag2_c)};
`else
            opnd_q <= mag1_c;
            acc_q  <= {{(WIDTH + 1){1'b0}}, mag2_c};
`endif
        end else if (step_i) begin
            acc_q <= acc_nxt_c;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder plus multi-cycle multiply/divide sequencer with HI/LO.
// ALUCtrl_o is a pure decode of ALUOp_i/funct_i. MULT/MULTU (and DIV/DIVU when
// ALU_CTRL_SEQ_DIV_EN is defined) stall the pipeline for WIDTH+1 cycles and
// write HI/LO on the edge into DONE.
// Ports:
//   clk_i, rst_i       clock, synchronous active-low reset
//   valid_i            instruction valid
//   funct_i, ALUOp_i   decode inputs
//   src1_i, src2_i     rs / rt operands
//   ALUCtrl_o          combinational ALU control code
//   stall_o            combinational pipeline freeze
//   done_o             one-cycle pulse when HI/LO hold a new result
//   hi_o, lo_o         HI and LO registers
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [5:0]       funct_i,
    input  logic [OP_W-1:0]  ALUOp_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [OP_W-1:0]  ALUCtrl_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_t state_q;
    state_t state_nxt;

    logic [CODE_W-1:0] alu_ctrl_c;
    logic              rtype_c;
    logic              mul_req_c;
    logic              div_req_c;
    logic              is_signed_c;
    logic              load_c;
    logic              step_c;
    logic              last_c;
    logic [WIDTH-1:0]  res_hi_c;
    logic [WIDTH-1:0]  res_lo_c;

    // ALU control decode, independent of sequencer state
    always_comb begin
        alu_ctrl_c = ALU_NOP;
        case (ALUOp_i)
            OP_W'(ALUOP_RTYPE): begin
                case (funct_i)
                    FUNCT_ADD:   alu_ctrl_c = ALU_ADD;
                    FUNCT_SUB:   alu_ctrl_c = ALU_SUB;
                    FUNCT_AND:   alu_ctrl_c = ALU_AND;
                    FUNCT_OR:    alu_ctrl_c = ALU_OR;
                    FUNCT_SLT:   alu_ctrl_c = ALU_SLT;
                    FUNCT_SLL:   alu_ctrl_c = ALU_SLL;
                    FUNCT_SRLV:  alu_ctrl_c = ALU_SRLV;
                    FUNCT_MULT,
                    FUNCT_MULTU: alu_ctrl_c = ALU_MULT;
`ifdef ALU_CTRL_SEQ_DIV_EN
                    FUNCT_DIV,
                    FUNCT_DIVU:  alu_ctrl_c = ALU_DIV;
`endif
                    default:     alu_ctrl_c = ALU_NOP;
                endcase
            end
            OP_W'(ALUOP_ADDI):   alu_ctrl_c = ALU_ADD;
            OP_W'(ALUOP_SLTI):   alu_ctrl_c = ALU_SLT;
            OP_W'(ALUOP_ANDI):   alu_ctrl_c = ALU_AND_IMM;
            OP_W'(ALUOP_ORI):    alu_ctrl_c = ALU_OR_IMM;
            OP_W'(ALUOP_XORI):   alu_ctrl_c = ALU_XOR_IMM;
            OP_W'(ALUOP_LUI):    alu_ctrl_c = ALU_LUI;
            OP_W'(ALUOP_LOAD):   alu_ctrl_c = ALU_ADD;
            OP_W'(ALUOP_STORE):  alu_ctrl_c = ALU_ADD;
            OP_W'(ALUOP_BRANCH): alu_ctrl_c = ALU_NOP;
            OP_W'(ALUOP_SLTIU):  alu_ctrl_c = ALU_SLTU;
            default:             alu_ctrl_c = ALU_NOP;
        endcase
    end

    assign ALUCtrl_o = OP_W'(alu_ctrl_c);

    // Multiply/divide request qualification
    assign rtype_c     = valid_i && (ALUOp_i == OP_W'(ALUOP_RTYPE));
    assign mul_req_c   = rtype_c && is_mul_funct(funct_i);
    assign is_signed_c = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
`ifdef ALU_CTRL_SEQ_DIV_EN
    assign div_req_c   = rtype_c && is_div_funct(funct_i);
`else
    assign div_req_c   = 1'b0;
`endif

    // Next-state and datapath control
    always_comb begin
        state_nxt = state_q;
        load_c    = 1'b0;
        step_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_req_c) begin
                    state_nxt = MUL;
                    load_c    = 1'b1;
                end
`ifdef ALU_CTRL_SEQ_DIV_EN
                else if (div_req_c) begin
                    state_nxt = DIV;
                    load_c    = 1'b1;
                end
`endif
            end
            MUL: begin
                step_c = 1'b1;
                if (last_c) state_nxt = DONE;
            end
`ifdef ALU_CTRL_SEQ_DIV_EN
            DIV: begin
                step_c = 1'b1;
                if (last_c) state_nxt = DONE;
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stall covers the accept cycle and every iteration cycle; forced low in reset
`ifdef ALU_CTRL_SEQ_DIV_EN
    assign stall_o = rst_i && (load_c || (state_q == MUL) || (state_q == DIV));
`else
    assign stall_o = rst_i && (load_c || (state_q == MUL));
`endif

    // State, done pulse and HI/LO write on the final iteration
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            done_o  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            state_q <= state_nxt;
            done_o  <= (state_nxt == DONE);
            if (step_c && last_c) begin
                hi_o <= res_hi_c;
                lo_o <= res_lo_c;
            end
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (load_c),
        .step_i      (step_c),
`ifdef ALU_CTRL_SEQ_DIV_EN
        .is_div_i    (div_req_c),
`endif
        .is_signed_i (is_signed_c),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .last_c      (last_c),
        .res_hi_c    (res_hi_c),
        .res_lo_c    (res_lo_c)
    );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq at WIDTH=32: stimulus pushes expected
// {HI,LO} values, a monitor pops and compares on every done_o pulse.
module tb_alu_ctrl_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OP_W  = 4;
    localparam int          LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [5:0]       funct;
    logic [OP_W-1:0]  aluop;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [OP_W-1:0]  alu_ctrl;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .valid_i   (valid),
        .funct_i   (funct),
        .ALUOp_i   (aluop),
        .src1_i    (src1),
        .src2_i    (src2),
        .ALUCtrl_o (alu_ctrl),
        .stall_o   (stall),
        .done_o    (done),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        valid = v;
        aluop = op;
        funct = f;
        src1  = a;
        src2  = b;
    endtask

    // One decode vector: checks ALUCtrl_o and that no stall is raised
    task automatic dec_chk(input string nm, input logic v, input logic [3:0] op,
                           input logic [5:0] f, input logic [3:0] exp);
        drive(v, op, f, 32'd0, 32'd0);
        #1;
        chk({nm, "_ctrl"}, 64'(alu_ctrl), 64'(exp));
        chk({nm, "_stall"}, 64'(stall), 64'd0);
        @(posedge clk); #1;
    endtask

    // Present an R-type mul/div request in an IDLE cycle and check it is accepted
    task automatic issue(input string nm, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit push);
        if (push) sb_q.push_back(exp);
        drive(1'b1, 4'd1, f, a, b);
        #1;
        chk({nm, "_accept_stall"}, 64'(stall), 64'd1);
    endtask

    // Hold the request while stalled; check stall length and done cycle
    task automatic wait_done(input string nm);
        int stall_cnt = 1;
        int done_at   = -1;
        for (int k = 1; (k <= LAT + 8) && (done_at < 0); k++) begin
            @(posedge clk); #2;
            if (stall) stall_cnt++;
            if (done) done_at = k;
        end
        chk({nm, "_stall_cycles"}, 64'(stall_cnt), 64'(LAT));
        chk({nm, "_done_cycle"}, 64'(done_at), 64'(LAT));
    endtask

    // Monitor: compare HI/LO against the scoreboard on each done pulse
    initial begin
        logic [63:0] exp_v;
        forever begin
            @(posedge clk); #2;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("result_hilo", {hi, lo}, exp_v);
                end
            end
        end
    end

    initial begin
        int dcnt;
        rst_n = 1'b0;
        drive(1'b1, 4'd1, 6'd24, 32'd3, 32'd5);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;

        // Decode table
        dec_chk("rt_add",   1'b1, 4'b0001, 6'd32, 4'd2);
        dec_chk("rt_sub",   1'b1, 4'b0001, 6'd34, 4'd3);
        dec_chk("rt_slt",   1'b1, 4'b0001, 6'd42, 4'd4);
        dec_chk("op_andi",  1'b1, 4'b0100, 6'd0,  4'd7);
        dec_chk("op_xori",  1'b1, 4'b0110, 6'd0,  4'd9);
        dec_chk("rt_and",   1'b1, 4'b0001, 6'd36, 4'd0);
        dec_chk("rt_or",    1'b1, 4'b0001, 6'd37, 4'd1);
        dec_chk("rt_sll",   1'b1, 4'b0001, 6'd0,  4'd5);
        dec_chk("rt_srlv",  1'b1, 4'b0001, 6'd6,  4'd6);
        dec_chk("rt_other", 1'b1, 4'b0001, 6'd63, 4'd12);
        dec_chk("op_addi",  1'b1, 4'b0010, 6'd32, 4'd2);
        dec_chk("op_slti",  1'b1, 4'b0011, 6'd0,  4'd4);
        dec_chk("op_ori",   1'b1, 4'b0101, 6'd0,  4'd8);
        dec_chk("op_lui",   1'b1, 4'b0111, 6'd0,  4'd10);
        dec_chk("op_lw",    1'b1, 4'b1000, 6'd0,  4'd2);
        dec_chk("op_sw",    1'b1, 4'b1001, 6'd0,  4'd2);
        dec_chk("op_br",    1'b1, 4'b1010, 6'd0,  4'd12);
        dec_chk("op_sltiu", 1'b1, 4'b1011, 6'd0,  4'd13);
        dec_chk("op_zero",  1'b1, 4'b0000, 6'd32, 4'd12);
        dec_chk("op_f",     1'b1, 4'b1111, 6'd0,  4'd12);
        dec_chk("mult_nv",  1'b0, 4'b0001, 6'd24, 4'd11);
        dec_chk("multu_nv", 1'b0, 4'b0001, 6'd25, 4'd11);
`ifdef ALU_CTRL_SEQ_DIV_EN
        dec_chk("div_nv",   1'b0, 4'b0001, 6'd26, 4'd14);
`else
        dec_chk("div_nv",   1'b0, 4'b0001, 6'd26, 4'd12);
`endif

        // MULT -3 x 7
        issue("mult_neg", 6'd24, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        wait_done("mult_neg");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk("hold_hi", 64'(hi), 64'hFFFF_FFFF);

        // MULTU, then a second MULTU held from the done cycle
        issue("multu_a", 6'd25, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b1);
        wait_done("multu_a");
        drive(1'b1, 4'd1, 6'd25, 32'h1234_5678, 32'h0000_0100);
        #1;
        chk("done_cycle_no_accept", 64'(stall), 64'd0);
        @(posedge clk); #1;
        issue("multu_b", 6'd25, 32'h1234_5678, 32'h0000_0100, 64'h0000_0012_3456_7800, 1'b1);
        wait_done("multu_b");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;

        // MULT most-negative squared
        issue("mult_min", 6'd24, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        wait_done("mult_min");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;

`ifdef ALU_CTRL_SEQ_DIV_EN
        issue("div_neg", 6'd26, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        wait_done("div_neg");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        issue("divu_zero", 6'd27, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b1);
        wait_done("divu_zero");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        issue("div_negdiv", 6'd26, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b1);
        wait_done("div_negdiv");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        issue("divu", 6'd27, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1);
        wait_done("divu");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        issue("div_zero_s", 6'd26, 32'hFFFF_FFF8, 32'd0, 64'hFFFF_FFF8_FFFF_FFFF, 1'b1);
        wait_done("div_zero_s");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
`else
        // Divide not built: request is a plain no-op
        drive(1'b1, 4'd1, 6'd26, 32'd9, 32'd3);
        #1;
        chk("nodiv_ctrl", 64'(alu_ctrl), 64'd12);
        chk("nodiv_stall", 64'(stall), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            if (done || stall) dcnt++;
        end
        chk("nodiv_quiet", 64'(dcnt), 64'd0);
        chk("nodiv_hi", 64'(hi), 64'h4000_0000);
        chk("nodiv_lo", 64'(lo), 64'd0);
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
`endif

        // Reset in cycle 10 of a MULT aborts it
        issue("mult_abort", 6'd24, 32'd1234, 32'd5678, 64'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        dcnt = 0;
        for (int k = 0; k < LAT + 8; k++) begin
            @(posedge clk); #2;
            if (done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        @(posedge clk); #1;

        // Sequencer usable again after the abort
        issue("mult_post", 6'd24, 32'd5, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFEC, 1'b1);
        wait_done("mult_post");
        drive(1'b0, 4'd0, 6'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
